// File: rtl/dtw_stream_sequencer.sv
// Job sequencer feeding a DTW core: gates a query stream of qlen beats, waits for the core
// result and reports status. Optional WAIT_CORE watchdog enabled by defining DTW_SEQ_TIMEOUT_EN.
module dtw_stream_sequencer #(
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned QLEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                       S_AXIS_clk,
  input  logic                       S_AXIS_rst,

  input  logic                       cfg_start,
  input  logic [QLEN_WIDTH-1:0]      cfg_qlen,
  input  logic                       cfg_abort,
  input  logic                       err_clr,

  input  logic                       S_AXIS_tuser,
  input  logic                       S_AXIS_tvalid,
  output logic                       S_AXIS_tready,
  input  logic                       S_AXIS_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,

  output logic                       M_AXIS_tuser,
  output logic                       M_AXIS_tvalid,
  input  logic                       M_AXIS_tready,
  output logic                       M_AXIS_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] M_AXIS_tdata,

  input  logic                       core_done,
  input  logic [31:0]                core_score,

  output logic                       busy,
  output logic                       done_irq,
  output logic                       result_valid,
  output logic [31:0]                result_score,
  output logic [QLEN_WIDTH-1:0]      beats_accepted,
  output logic                       err_cfg,
  output logic                       err_short,
  output logic                       err_abort,
  output logic                       err_timeout
);

  typedef enum logic [1:0] {StIdle, StStream, StWaitCore} state_e;

  state_e                state_q;
  logic [QLEN_WIDTH-1:0] qlen_q;
  logic [QLEN_WIDTH-1:0] beats_q;
  logic [QLEN_WIDTH-1:0] qlen_last;
  logic                  result_valid_q;
  logic [31:0]           result_score_q;
  logic                  done_irq_q;
  logic                  err_cfg_q;
  logic                  err_short_q;
  logic                  err_abort_q;

  logic stream_en;
  logic beat_first;
  logic beat_last;
  logic xfer;

  // Upstream tuser is regenerated locally from the beat counter.
  logic unused_tuser;
  assign unused_tuser = S_AXIS_tuser;

`ifdef DTW_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            err_timeout_q;
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Abort suppresses the handshake so an aborted cycle never moves a beat.
  assign stream_en  = (state_q == StStream) && !cfg_abort;
  assign qlen_last  = qlen_q - QLEN_WIDTH'(1);
  assign beat_first = (beats_q == '0);
  assign beat_last  = (beats_q == qlen_last);

  assign M_AXIS_tvalid = stream_en & S_AXIS_tvalid;
  assign S_AXIS_tready = stream_en & M_AXIS_tready;
  assign M_AXIS_tdata  = stream_en ? S_AXIS_tdata : '0;
  assign M_AXIS_tuser  = M_AXIS_tvalid & beat_first;
  assign M_AXIS_tlast  = M_AXIS_tvalid & (beat_last | S_AXIS_tlast);
  assign xfer          = M_AXIS_tvalid & M_AXIS_tready;

  assign busy           = (state_q != StIdle);
  assign done_irq       = done_irq_q;
  assign result_valid   = result_valid_q;
  assign result_score   = result_score_q;
  assign beats_accepted = beats_q;
  assign err_cfg        = err_cfg_q;
  assign err_short      = err_short_q;
  assign err_abort      = err_abort_q;

  always_ff @(posedge S_AXIS_clk or negedge S_AXIS_rst) begin
    if (!S_AXIS_rst) begin
      state_q        <= StIdle;
      qlen_q         <= '0;
      beats_q        <= '0;
      result_valid_q <= 1'b0;
      result_score_q <= '0;
      done_irq_q     <= 1'b0;
      err_cfg_q      <= 1'b0;
      err_short_q    <= 1'b0;
      err_abort_q    <= 1'b0;
`ifdef DTW_SEQ_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      done_irq_q <= 1'b0;
      // Clear first so that any set below in the same cycle takes precedence.
      if (err_clr) begin
        err_cfg_q   <= 1'b0;
        err_short_q <= 1'b0;
        err_abort_q <= 1'b0;
`ifdef DTW_SEQ_TIMEOUT_EN
        err_timeout_q <= 1'b0;
`endif
      end
`ifdef DTW_SEQ_TIMEOUT_EN
      if (state_q != StWaitCore) tmo_cnt_q <= '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            if (cfg_qlen != '0) begin
              qlen_q         <= cfg_qlen;
              beats_q        <= '0;
              result_valid_q <= 1'b0;
              state_q        <= StStream;
            end else begin
              err_cfg_q <= 1'b1;
            end
          end
        end
        StStream: begin
          if (cfg_abort) begin
            err_abort_q <= 1'b1;
            state_q     <= StIdle;
          end else if (xfer) begin
            beats_q <= beats_q + QLEN_WIDTH'(1);
            if (beat_last || S_AXIS_tlast) state_q <= StWaitCore;
            if (S_AXIS_tlast && !beat_last) err_short_q <= 1'b1;
          end
        end
        StWaitCore: begin
          if (cfg_abort) begin
            err_abort_q <= 1'b1;
            state_q     <= StIdle;
          end else if (core_done) begin
            result_score_q <= core_score;
            result_valid_q <= 1'b1;
            done_irq_q     <= 1'b1;
            state_q        <= StIdle;
          end
`ifdef DTW_SEQ_TIMEOUT_EN
          else if (tmo_cnt_q == TmoLast) begin
            err_timeout_q <= 1'b1;
            done_irq_q    <= 1'b1;
            state_q       <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/dtw_stream_sequencer.md
DTW_STREAM_SEQUENCER -- requirements
Module: dtw_stream_sequencer

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 32, giving the stream data width.
REQ-002 SHALL have parameter QLEN_WIDTH, default 16, giving the query-length and beat-counter width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the core-done watchdog limit.
REQ-004 SHALL have one clock and an asynchronous active-low reset: S_AXIS_clk  in  1  clock; S_AXIS_rst  in  1  asynchronous reset, active low.
REQ-005 SHALL have cfg_start  in  1  one-cycle job start pulse.
REQ-006 SHALL have cfg_qlen  in  QLEN_WIDTH  query length in beats, sampled on accepted start.
REQ-007 SHALL have cfg_abort  in  1  one-cycle abort pulse.
REQ-008 SHALL have err_clr  in  1  one-cycle pulse that clears sticky errors.
REQ-009 SHALL have the upstream stream: S_AXIS_tuser in 1, S_AXIS_tvalid in 1, S_AXIS_tready out 1, S_AXIS_tlast in 1, S_AXIS_tdata in AXIS_DATA_WIDTH.
REQ-010 SHALL have the core-side stream: M_AXIS_tuser out 1, M_AXIS_tvalid out 1, M_AXIS_tready in 1, M_AXIS_tlast out 1, M_AXIS_tdata out AXIS_DATA_WIDTH.
REQ-011 SHALL have core_done  in  1  one-cycle DTW-core completion pulse, and core_score  in  32  the score valid with core_done.
REQ-012 SHALL have status outputs: busy out 1; done_irq out 1 (one-cycle pulse); result_valid out 1; result_score out 32; beats_accepted out QLEN_WIDTH; err_cfg, err_short, err_abort, err_timeout out 1 each (sticky).

Function
REQ-013 SHALL implement states IDLE, STREAM, WAIT_CORE; busy SHALL be 1 in STREAM and WAIT_CORE.
REQ-014 In IDLE, cfg_start with cfg_qlen!=0 SHALL latch qlen, clear beats_accepted and result_valid, and enter STREAM next cycle.
REQ-015 In IDLE, cfg_start with cfg_qlen==0 SHALL be ignored and set err_cfg.
REQ-016 cfg_start outside IDLE SHALL be ignored with no error.
REQ-017 In STREAM: M_AXIS_tvalid=S_AXIS_tvalid, S_AXIS_tready=M_AXIS_tready, and tdata passes through combinationally (zero latency); outside STREAM, both tvalid and tready SHALL be 0.
REQ-018 A beat is transferred when M_AXIS_tvalid and M_AXIS_tready are both 1; beats_accepted SHALL increment by 1 per transferred beat.
REQ-019 M_AXIS_tuser SHALL be 1 only on beat 0; upstream tuser SHALL be discarded.
REQ-020 M_AXIS_tlast SHALL be 1 on beat qlen-1 regardless of upstream tlast; after that beat, the FSM SHALL enter WAIT_CORE.
REQ-021 Upstream tlast on a beat before qlen-1 SHALL be forwarded as M_AXIS_tlast, SHALL set err_short, and SHALL enter WAIT_CORE.
REQ-022 In WAIT_CORE, core_done SHALL latch core_score into result_score, set result_valid, pulse done_irq for one cycle, and return to IDLE.
REQ-023 core_done outside WAIT_CORE SHALL be ignored.
REQ-024 cfg_abort in STREAM or WAIT_CORE SHALL return to IDLE next cycle, set err_abort, and leave result_valid at 0; abort SHALL win over a simultaneous start, beat or core_done.
REQ-025 err_clr SHALL clear all sticky errors; a set event in the same cycle SHALL win.
REQ-026 The beat counter SHALL not wrap; qlen max = 2^QLEN_WIDTH-1.

Reset
REQ-027 Asserting S_AXIS_rst (low) SHALL immediately force IDLE and zero every output and register, including mid-stream or mid-wait.
REQ-028 Sequential logic SHALL leave reset on a clock edge after S_AXIS_rst deasserts.

Configuration
REQ-029 With macro DTW_SEQ_TIMEOUT_EN defined, a counter SHALL run in WAIT_CORE; when it reaches TIMEOUT_CYCLES without core_done, the block SHALL set err_timeout, pulse done_irq, keep result_valid 0, and return to IDLE.
REQ-030 Without DTW_SEQ_TIMEOUT_EN, the block SHALL have no counter, WAIT_CORE SHALL wait indefinitely, and err_timeout SHALL be tied to 0.

Verification
REQ-031 start qlen=4, 4 beats with M_AXIS_tready=1, then core_done with score 0x1234 -> tuser on beat 0, tlast on beat 3, beats_accepted=4, result_score=0x1234, one done_irq pulse, busy=0.
REQ-032 qlen=8, upstream tlast on beat 2 -> M tlast on beat 2, err_short=1, WAIT_CORE, tready=0 afterwards.
REQ-033 qlen=3, 5 upstream beats offered without tlast -> only 3 transferred, tlast forced on beat 2, S_AXIS_tready=0 for beats 4-5.
REQ-034 M_AXIS_tready toggling 1/0 each cycle, qlen=5 -> exactly 5 transfers, no duplicated or dropped data.
REQ-035 abort and core_done in the same WAIT_CORE cycle -> IDLE, err_abort=1, result_valid=0, no done_irq; start with qlen=0 -> err_cfg=1, busy stays 0.
REQ-036 DTW_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no core_done -> err_timeout=1 and done_irq 16 cycles after WAIT_CORE entry; reset asserted mid-STREAM -> all outputs 0 immediately.
